// File: rtl/alu_multicycle.sv
// Handshaked EX-stage ALU: single-cycle logic/arith ops plus iterative
// shift-add multiply and restoring divide, result held until consumed.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [3:0]       ALUCtrl_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0]     CNT_LAST = (SHW+1)'(WIDTH - 1);
  localparam logic [SHW:0]     CNT_ONE  = (SHW+1)'(1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [3:0] OP_AND  = 4'd0,  OP_XOR  = 4'd1,  OP_SLL = 4'd2,  OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4,  OP_MUL  = 4'd5,  OP_ADDI = 4'd6, OP_SRAI = 4'd7;
  localparam logic [3:0] OP_LW   = 4'd8,  OP_SW   = 4'd9,  OP_BEQ = 4'd10, OP_OR  = 4'd11;
  localparam logic [3:0] OP_SRL  = 4'd12, OP_DIV  = 4'd13, OP_REM = 4'd14, OP_SLT = 4'd15;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, acc_q;
  logic [SHW:0]       cnt_q;
  logic               quo_neg_q, rem_neg_q;

  logic               accept, is_div, div_special;
  logic [WIDTH-1:0]   imm_res, mul_acc, div_rem, div_quo, div_res;
  logic [WIDTH:0]     div_trial;

  function automatic logic [WIDTH-1:0] alu_single(input logic [3:0] op,
                                                  input logic signed [WIDTH-1:0] a,
                                                  input logic signed [WIDTH-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (op)
      OP_AND:                          return a & b;
      OP_XOR:                          return a ^ b;
      OP_OR:                           return a | b;
      OP_SLL:                          return a << sh;
      OP_SRL:                          return $unsigned(a) >> sh;
      OP_SRAI:                         return a >>> sh;
      OP_ADD, OP_ADDI, OP_LW, OP_SW:   return a + b;
      OP_SUB, OP_BEQ:                  return a - b;
      OP_SLT:                          return (a < b) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
      default:                         return '0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] sign_fix(input logic [WIDTH-1:0] mag, input logic neg);
    return neg ? -mag : mag;
  endfunction

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign accept  = valid_i && ready_o;
  assign is_div  = (ALUCtrl_i == OP_DIV) || (ALUCtrl_i == OP_REM);
  // Zero divisor and MIN/-1 overflow never enter the iterative divider.
  assign div_special = is_div && ((data2_i == '0) || (data1_i == MIN_VAL && data2_i == '1));

  always_comb begin
    imm_res = alu_single(ALUCtrl_i, data1_i, data2_i);
    if (ALUCtrl_i == OP_DIV)
      imm_res = (data2_i == '0) ? '1 : data1_i;
    else if (ALUCtrl_i == OP_REM)
      imm_res = (data2_i == '0) ? data1_i : '0;
  end

  always_comb begin
    mul_acc   = acc_q + (b_q[0] ? a_q : '0);
    div_trial = {acc_q, a_q[WIDTH-1]} - {1'b0, b_q};
    if (!div_trial[WIDTH]) begin
      div_rem = div_trial[WIDTH-1:0];
      div_quo = {a_q[WIDTH-2:0], 1'b1};
    end else begin
      div_rem = {acc_q[WIDTH-2:0], a_q[WIDTH-1]};
      div_quo = {a_q[WIDTH-2:0], 1'b0};
    end
    div_res = (op_q == OP_DIV) ? sign_fix(div_quo, quo_neg_q) : sign_fix(div_rem, rem_neg_q);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) begin
        if (ALUCtrl_i == OP_MUL)        state_d = MUL;
        else if (is_div && !div_special) state_d = DIV;
        else                             state_d = DONE;
      end
      MUL, DIV: if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:     if (ready_i)           state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      data_o    <= '0;
      zero_o    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          op_q  <= ALUCtrl_i;
          acc_q <= '0;
          cnt_q <= '0;
          if (ALUCtrl_i == OP_MUL) begin
            a_q <= data1_i;
            b_q <= data2_i;
          end else if (is_div && !div_special) begin
            a_q       <= abs_val(data1_i);
            b_q       <= abs_val(data2_i);
            quo_neg_q <= data1_i[WIDTH-1] ^ data2_i[WIDTH-1];
            rem_neg_q <= data1_i[WIDTH-1];
          end else begin
            data_o <= imm_res;
            zero_o <= (imm_res == '0);
          end
        end
        MUL: begin
          acc_q <= mul_acc;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            data_o <= mul_acc;
            zero_o <= (mul_acc == '0);
          end
        end
        DIV: begin
          acc_q <= div_rem;
          a_q   <= div_quo;
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            data_o <= div_res;
            zero_o <= (div_res == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
